// File: rtl/sum8_check_pkg.sv
// Shared types and defaults for the sum8 result checker.
// Holds the FSM state type and the saturating counter step.
package sum8_check_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } chk_state_t;

  localparam int WIDTH_DEF      = 8;
  localparam int NUM_CHECKS_DEF = 7;
  localparam int CNT_W_DEF      = 8;

  // Counter step that sticks at the w-bit all-ones value.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input int unsigned w
  );
    logic [31:0] top;
    top = (32'd1 << w) - 32'd1;
    return (v >= top) ? top : v + 32'd1;
  endfunction

endpackage

// File: rtl/sum8_ref_model.sv
// Golden running-sum accumulator for sum8 checkers.
// clr reloads the initial value; en adds i with carry dropped.
module sum8_ref_model
  import sum8_check_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int INIT_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] acc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= WIDTH'(INIT_VAL);
    end else if (en) begin
      acc <= acc + i;
    end
  end

endmodule

// File: rtl/sum8_result_checker.sv
// Compares a sum8 DUT output stream against a running-sum model.
// Counts mismatches, captures the first one, flags pass/done.
module sum8_result_checker
  import sum8_check_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int NUM_CHECKS = NUM_CHECKS_DEF,
  parameter int INIT_VAL   = 0,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] i,
  input  logic [WIDTH-1:0] o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_count,
  output logic             err_seen,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_act
);

  if (NUM_CHECKS < 1 || NUM_CHECKS > (1 << CNT_W)) begin : g_bad_cfg
    $error("sum8_result_checker: NUM_CHECKS must be 1..2**CNT_W");
  end

  chk_state_t       state;
  chk_state_t       state_d;
  logic             busy_d;
  logic             done_d;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] k;
  logic [CNT_W-1:0] cnt_nxt;
  logic             running;
  logic             launch;
  logic             mis;
  logic             last;

  assign running = (state == RUN);
  assign launch  = start && !running;
  assign mis     = running && (o != acc);
  assign last    = running && (k == CNT_W'(NUM_CHECKS - 1));
  assign cnt_nxt = mis
    ? CNT_W'(sat_inc(32'(mismatch_count), CNT_W))
    : mismatch_count;

  sum8_ref_model #(
    .WIDTH    (WIDTH),
    .INIT_VAL (INIT_VAL)
  ) u_ref (
    .clk (clk),
    .rst (rst),
    .clr (launch),
    .en  (running),
    .i   (i),
    .acc (acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (last)  state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst || launch) begin
      k              <= '0;
      pass           <= 1'b0;
      mismatch_count <= '0;
      err_seen       <= 1'b0;
      first_err_idx  <= '0;
      first_err_exp  <= '0;
      first_err_act  <= '0;
    end else if (running) begin
      // k parks on the final index instead of running past it
      k              <= last ? k : k + 1'b1;
      mismatch_count <= cnt_nxt;
      if (mis && !err_seen) begin
        err_seen      <= 1'b1;
        first_err_idx <= k;
        first_err_exp <= acc;
        first_err_act <= o;
      end
      if (last) begin
        pass <= (cnt_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_sum8_result_checker.sv
// Randomized and directed bench for sum8_result_checker.
// A second instance with a 2-bit counter covers saturation.
module tb_sum8_result_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] i = '0;
  logic [7:0] o = '0;

  logic       busy, done, pass, err_seen;
  logic [7:0] mc, fe_idx, fe_exp, fe_act;

  logic       s_busy, s_done, s_pass, s_err;
  logic [1:0] s_mc, s_idx;
  logic [7:0] s_exp, s_act;

  always #5 clk = ~clk;

  sum8_result_checker dut (
    .clk(clk), .rst(rst), .start(start), .i(i), .o(o),
    .busy(busy), .done(done), .pass(pass),
    .mismatch_count(mc), .err_seen(err_seen),
    .first_err_idx(fe_idx), .first_err_exp(fe_exp),
    .first_err_act(fe_act)
  );

  sum8_result_checker #(.NUM_CHECKS(4), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .start(start), .i(i), .o(o),
    .busy(s_busy), .done(s_done), .pass(s_pass),
    .mismatch_count(s_mc), .err_seen(s_err),
    .first_err_idx(s_idx), .first_err_exp(s_exp),
    .first_err_act(s_act)
  );

  int nvec = 0;
  int nerr = 0;

  logic [7:0] iv[7];
  logic [7:0] ov[7];
  int m_cnt, m_idx, m_exp, m_act;
  bit m_err;

  int         done_at;
  logic       done_hold;
  logic       busy0, done0, err0;
  logic [7:0] mc0;
  logic [1:0] hist[7];

  // Golden: expected o at compare c is the sum of earlier inputs mod 256.
  task automatic model();
    int s;
    s = 0; m_cnt = 0; m_err = 0; m_idx = 0; m_exp = 0; m_act = 0;
    for (int c = 0; c < 7; c++) begin
      if (int'(ov[c]) != s % 256) begin
        if (!m_err) begin
          m_err = 1; m_idx = c; m_exp = s % 256; m_act = int'(ov[c]);
        end
        m_cnt++;
      end
      s += int'(iv[c]);
    end
  endtask

  task automatic make_good();
    int s;
    s = 0;
    for (int c = 0; c < 7; c++) begin
      ov[c] = 8'(s % 256);
      s += int'(iv[c]);
    end
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic do_run(input int mid_k);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy0 = busy; done0 = done; err0 = err_seen; mc0 = mc;
    done_at = -1;
    for (int c = 0; c < 7; c++) begin
      i = iv[c]; o = ov[c];
      start = (c == mid_k);
      @(posedge clk); #1;
      hist[c] = s_mc;
      if (done && done_at < 0) done_at = c + 1;
    end
    start = 1'b0; i = '0; o = '0;
    @(posedge clk); #1;
    done_hold = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %0d want 0", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_done got %0d want 0", done); end
    nvec++; if (pass !== 1'b0) begin nerr++; $display("FAIL rst_pass got %0d want 0", pass); end
    nvec++; if (mc !== 8'd0) begin nerr++; $display("FAIL rst_cnt got %0d want 0", mc); end
    nvec++; if (err_seen !== 1'b0) begin nerr++; $display("FAIL rst_err got %0d want 0", err_seen); end
    nvec++; if ({fe_idx, fe_exp, fe_act} !== 24'd0) begin
      nerr++; $display("FAIL rst_first got %0h want 0", {fe_idx, fe_exp, fe_act});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_spec_pass();
    iv = '{8'd3, 8'd5, 8'd7, 8'd2, 8'd4, 8'd6, 8'd0};
    ov = '{8'd0, 8'd3, 8'd8, 8'd15, 8'd17, 8'd21, 8'd27};
    do_run(-1);
    nvec++; if (busy0 !== 1'b1) begin nerr++; $display("FAIL pass_busy got %0d want 1", busy0); end
    nvec++; if (done_at != 7) begin nerr++; $display("FAIL pass_done_at got %0d want 7", done_at); end
    nvec++; if (done_hold !== 1'b1) begin nerr++; $display("FAIL pass_hold got %0d want 1", done_hold); end
    nvec++; if (pass !== 1'b1) begin nerr++; $display("FAIL pass_pass got %0d want 1", pass); end
    nvec++; if (mc !== 8'd0) begin nerr++; $display("FAIL pass_cnt got %0d want 0", mc); end
    nvec++; if (err_seen !== 1'b0) begin nerr++; $display("FAIL pass_err got %0d want 0", err_seen); end
  endtask

  task automatic test_single_err();
    iv = '{8'd3, 8'd5, 8'd7, 8'd2, 8'd4, 8'd6, 8'd0};
    make_good();
    ov[2] = 8'd9;
    do_run(-1);
    nvec++; if (mc !== 8'd1) begin nerr++; $display("FAIL one_cnt got %0d want 1", mc); end
    nvec++; if (fe_idx !== 8'd2) begin nerr++; $display("FAIL one_idx got %0d want 2", fe_idx); end
    nvec++; if (fe_exp !== 8'd8) begin nerr++; $display("FAIL one_exp got %0d want 8", fe_exp); end
    nvec++; if (fe_act !== 8'd9) begin nerr++; $display("FAIL one_act got %0d want 9", fe_act); end
    nvec++; if (pass !== 1'b0) begin nerr++; $display("FAIL one_pass got %0d want 0", pass); end
    nvec++; if (err_seen !== 1'b1) begin nerr++; $display("FAIL one_err got %0d want 1", err_seen); end
  endtask

  task automatic test_restart();
    iv = '{8'd3, 8'd5, 8'd7, 8'd2, 8'd4, 8'd6, 8'd0};
    make_good();
    do_run(-1);
    nvec++; if (done0 !== 1'b0) begin nerr++; $display("FAIL rerun_done0 got %0d want 0", done0); end
    nvec++; if (mc0 !== 8'd0) begin nerr++; $display("FAIL rerun_cnt0 got %0d want 0", mc0); end
    nvec++; if (err0 !== 1'b0) begin nerr++; $display("FAIL rerun_err0 got %0d want 0", err0); end
    nvec++; if (pass !== 1'b1) begin nerr++; $display("FAIL rerun_pass got %0d want 1", pass); end
  endtask

  task automatic test_wrap();
    iv = '{8'd200, 8'd100, 8'd50, 8'd25, 8'd10, 8'd5, 8'd1};
    ov = '{8'd0, 8'd200, 8'd44, 8'd94, 8'd119, 8'd129, 8'd134};
    do_run(-1);
    nvec++; if (pass !== 1'b1) begin nerr++; $display("FAIL wrap_pass got %0d want 1", pass); end
    nvec++; if (mc !== 8'd0) begin nerr++; $display("FAIL wrap_cnt got %0d want 0", mc); end
  endtask

  task automatic test_stuck();
    iv = '{8'd3, 8'd5, 8'd7, 8'd2, 8'd4, 8'd6, 8'd0};
    for (int c = 0; c < 7; c++) ov[c] = 8'hff;
    do_run(-1);
    nvec++; if (mc !== 8'd7) begin nerr++; $display("FAIL stuck_cnt got %0d want 7", mc); end
    nvec++; if (fe_idx !== 8'd0) begin nerr++; $display("FAIL stuck_idx got %0d want 0", fe_idx); end
    nvec++; if (fe_exp !== 8'd0) begin nerr++; $display("FAIL stuck_exp got %0d want 0", fe_exp); end
    nvec++; if (fe_act !== 8'd255) begin nerr++; $display("FAIL stuck_act got %0d want 255", fe_act); end
    nvec++; if (pass !== 1'b0) begin nerr++; $display("FAIL stuck_pass got %0d want 0", pass); end
  endtask

  task automatic test_saturate();
    int want;
    iv = '{8'd3, 8'd5, 8'd7, 8'd2, 8'd4, 8'd6, 8'd0};
    for (int c = 0; c < 7; c++) ov[c] = 8'hff;
    do_run(-1);
    for (int c = 0; c < 7; c++) begin
      want = (c + 1 < 3) ? c + 1 : 3;
      nvec++; if (hist[c] !== 2'(want)) begin
        nerr++; $display("FAIL sat_cnt[%0d] got %0d want %0d", c, hist[c], want);
      end
    end
    nvec++; if (s_done !== 1'b1 || s_busy !== 1'b0) begin
      nerr++; $display("FAIL sat_done got %0d/%0d want 1/0", s_done, s_busy);
    end
    nvec++; if (s_pass !== 1'b0 || s_err !== 1'b1) begin
      nerr++; $display("FAIL sat_flags got %0d/%0d want 0/1", s_pass, s_err);
    end
    nvec++; if ({s_idx, s_exp, s_act} !== {2'd0, 8'd0, 8'd255}) begin
      nerr++; $display("FAIL sat_first got %0d/%0d/%0d want 0/0/255", s_idx, s_exp, s_act);
    end
  endtask

  task automatic test_mid_start();
    iv = '{8'd3, 8'd5, 8'd7, 8'd2, 8'd4, 8'd6, 8'd0};
    make_good();
    do_run(3);
    nvec++; if (done_at != 7) begin nerr++; $display("FAIL mid_done_at got %0d want 7", done_at); end
    nvec++; if (pass !== 1'b1) begin nerr++; $display("FAIL mid_pass got %0d want 1", pass); end
  endtask

  task automatic test_rst_abort();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      i = 8'd1; o = 8'hff;
      @(posedge clk); #1;
    end
    nvec++; if (mc !== 8'd4) begin nerr++; $display("FAIL abort_pre got %0d want 4", mc); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; i = '0; o = '0;
    nvec++; if ({busy, done, pass, err_seen} !== 4'b0) begin
      nerr++; $display("FAIL abort_flags got %b want 0000", {busy, done, pass, err_seen});
    end
    nvec++; if ({mc, fe_idx, fe_exp, fe_act} !== 32'd0) begin
      nerr++; $display("FAIL abort_data got %0h want 0", {mc, fe_idx, fe_exp, fe_act});
    end
    repeat (8) @(posedge clk);
    #1;
    nvec++; if (done !== 1'b0 || busy !== 1'b0) begin
      nerr++; $display("FAIL abort_idle got %0d/%0d want 0/0", done, busy);
    end
  endtask

  task automatic test_random();
    int mk;
    for (int n = 0; n < 30; n++) begin
      for (int c = 0; c < 7; c++) iv[c] = 8'($urandom);
      make_good();
      for (int c = 0; c < 7; c++) begin
        if ($urandom_range(0, 3) == 0) ov[c] = ov[c] ^ 8'($urandom_range(1, 255));
      end
      mk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1;
      model();
      do_run(mk);
      nvec++; if (done_at != 7) begin nerr++; $display("FAIL rnd%0d_done got %0d want 7", n, done_at); end
      nvec++; if (mc !== 8'(m_cnt)) begin nerr++; $display("FAIL rnd%0d_cnt got %0d want %0d", n, mc, m_cnt); end
      nvec++; if (pass !== (m_cnt == 0)) begin nerr++; $display("FAIL rnd%0d_pass got %0d want %0d", n, pass, m_cnt == 0); end
      nvec++; if (err_seen !== m_err) begin nerr++; $display("FAIL rnd%0d_err got %0d want %0d", n, err_seen, m_err); end
      nvec++; if ({fe_idx, fe_exp, fe_act} !== {8'(m_idx), 8'(m_exp), 8'(m_act)}) begin
        nerr++; $display("FAIL rnd%0d_first got %0d/%0d/%0d want %0d/%0d/%0d",
                         n, fe_idx, fe_exp, fe_act, m_idx, m_exp, m_act);
      end
    end
  endtask

  initial begin
    test_reset();
    test_spec_pass();
    test_single_err();
    test_restart();
    test_wrap();
    test_stuck();
    test_saturate();
    test_mid_start();
    test_rst_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
